// File: rtl/cell_partial_histogram_builder.sv
// cell_partial_histogram_builder
//   Builds the CELL_ROWS per-row partial histograms of one HOG cell from a
//   stream of per-pixel (bin, magnitude) votes, one vote per cycle. After
//   CELL_ROWS*CELL_COLS accepted votes the whole cell is presented as one
//   packed vector and held until the downstream stage takes it. There is no
//   double buffering: input stalls while a finished cell waits.
//
// Ports
//   clk, rst_n         clock; synchronous active-low reset
//   in_valid/in_ready  vote handshake
//   in_bin, in_mag     orientation bin and unsigned magnitude of the vote
//   out_valid/out_ready cell handshake
//   partial_histogram  bin b of row r at [(r*BINS+b)*BIN_WIDTH +: BIN_WIDTH]
//   bin_err            (only with CELL_HIST_BIN_ERR_EN) sticky flag, set the
//                      cycle after a vote with in_bin >= BINS is accepted
//
// Configuration macro: CELL_HIST_BIN_ERR_EN

// One row's histogram: BINS accumulators sharing a single vote port.
module cell_phb_row #(
  parameter int BINS          = 9,
  parameter int BIN_IDX_WIDTH = 4,
  parameter int MAG_WIDTH     = 8,
  parameter int BIN_WIDTH     = 11
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr,
  input  logic                           vote_en,
  input  logic [BIN_IDX_WIDTH-1:0]       bin,
  input  logic [MAG_WIDTH-1:0]           mag,
  output logic [BINS-1:0][BIN_WIDTH-1:0] hist
);
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      hist <= '0;
    end else if (vote_en) begin
      for (int b = 0; b < BINS; b++) begin
        if (int'(bin) == b) hist[b] <= hist[b] + BIN_WIDTH'(mag);
      end
    end
  end
endmodule

module cell_partial_histogram_builder #(
  parameter int MAG_WIDTH     = 8,
  parameter int BINS          = 9,
  parameter int BIN_IDX_WIDTH = 4,
  parameter int CELL_COLS     = 8,
  parameter int CELL_ROWS     = 8,
  parameter int BIN_WIDTH     = MAG_WIDTH + $clog2(CELL_COLS),
  parameter int OUTPUT_WIDTH  = BIN_WIDTH * BINS * CELL_ROWS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BIN_IDX_WIDTH-1:0] in_bin,
  input  logic [MAG_WIDTH-1:0]     in_mag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUTPUT_WIDTH-1:0]  partial_histogram
`ifdef CELL_HIST_BIN_ERR_EN
  ,
  output logic                     bin_err
`endif
);
  localparam int COL_W    = (CELL_COLS > 1) ? $clog2(CELL_COLS) : 1;
  localparam int ROW_W    = (CELL_ROWS > 1) ? $clog2(CELL_ROWS) : 1;
  localparam int ROW_BITS = BINS * BIN_WIDTH;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(CELL_COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(CELL_ROWS - 1);

  typedef enum logic {ACCUM, FULL} state_t;

  state_t           state, state_nxt;
  logic [COL_W-1:0] col_cnt, col_nxt;
  logic [ROW_W-1:0] row_cnt, row_nxt;
  logic             clr;
  logic             accept;
  logic             bin_ok;

  logic [CELL_ROWS-1:0][ROW_BITS-1:0] rows;

  assign accept = in_valid & in_ready;
  // Compare in 32 bits so BINS == 2**BIN_IDX_WIDTH does not wrap.
  assign bin_ok = int'(in_bin) < BINS;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ACCUM;
      col_cnt <= '0;
      row_cnt <= '0;
    end else begin
      state   <= state_nxt;
      col_cnt <= col_nxt;
      row_cnt <= row_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    col_nxt   = col_cnt;
    row_nxt   = row_cnt;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    clr       = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (col_cnt == LAST_COL) begin
            col_nxt = '0;
            if (row_cnt == LAST_ROW) begin
              // Final vote of the cell; it still lands in the accumulators
              // on this edge, so the held vector is complete next cycle.
              row_nxt   = '0;
              state_nxt = FULL;
            end else begin
              row_nxt = row_cnt + 1'b1;
            end
          end else begin
            col_nxt = col_cnt + 1'b1;
          end
        end
      end
      FULL: begin
        out_valid = 1'b1;
        if (out_ready) begin
          clr       = 1'b1;
          state_nxt = ACCUM;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  // Accumulators double as the output register: they are frozen while FULL
  // because no vote is accepted in that state.
  for (genvar r = 0; r < CELL_ROWS; r++) begin : g_row
    cell_phb_row #(
      .BINS(BINS), .BIN_IDX_WIDTH(BIN_IDX_WIDTH),
      .MAG_WIDTH(MAG_WIDTH), .BIN_WIDTH(BIN_WIDTH)
    ) u_row (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr),
      .vote_en (accept && bin_ok && (row_cnt == ROW_W'(r))),
      .bin     (in_bin),
      .mag     (in_mag),
      .hist    (rows[r])
    );
  end

  assign partial_histogram = OUTPUT_WIDTH'(rows);

`ifdef CELL_HIST_BIN_ERR_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                bin_err <= 1'b0;
    else if (accept && !bin_ok) bin_err <= 1'b1;
  end
`endif

endmodule
